burst_port_arbiter: RTL and testbench
=====================================

// Module: burst_port_arbiter
// PURPOSE
// - Shares one downstream valid/ready port (e.g. a cache/memory request port) among N requesters.
// - Uses round-robin priority and keeps the grant for the whole multi-beat burst, until the last beat.
// - Zero-latency datapath: the winner's beat is muxed combinationally to the output.
// - Priority advances only when a burst completes, so no requester can starve another.
// PARAMETERS
// - N        2   number of requesters (>=2)
// - DW       32  beat data width
// - PRI_RST  0   requester index holding top priority after reset (0..N-1)
// - MAX_HOLD 16  watchdog limit in cycles for one burst (used only with the macro, >=2)
// PORTS
// - clk        in   1       clock, rising edge
// - rst_n      in   1       asynchronous active-low reset
// - req_valid  in   N       per-requester beat valid
// - req_last   in   N       per-requester last-beat flag; qualified by req_valid
// - req_data   in   N*DW    per-requester beat data; slice i = req_data[i*DW +: DW]
// - req_ready  out  N       per-requester accept; at most one bit set
// - out_valid  out  1       downstream beat valid
// - out_last   out  1       downstream last-beat flag
// - out_data   out  DW      downstream beat data
// - out_id     out  $clog2(N)  index of the requester currently driving the output
// - out_ready  in   1       downstream accept
// - busy       out  1       1 while a burst is locked (state LOCK)
// - wdog_err   out  1       one-cycle pulse when the watchdog aborts a burst
// BEHAVIOUR
// Reset values
// - Async reset: state=IDLE, ptr=PRI_RST, lock_id=0, hold_cnt=0, busy=0, wdog_err=0.
// - All combinational outputs are 0 while in reset.
// State machine (two states)
// - IDLE:
//   - win = first i with req_valid[i], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   - out_* = win's signals, and req_ready[win] = out_ready.
//   - With no request: out_valid=0, req_ready=0, out_id=0.
// - LOCK:
//   - Only lock_id is routed: out_valid = req_valid[lock_id], req_ready[lock_id] = out_ready.
//   - All other req_ready bits are 0 and other requests are ignored.
// Transfers and transitions
// - A beat transfers when out_valid & out_ready.
// - IDLE, accepted beat with last=0: go to LOCK, lock_id <= win.
// - IDLE, accepted beat with last=1 (single-beat burst): stay in IDLE, ptr <= (win+1) mod N.
// - LOCK, accepted beat with last=1: go to IDLE, ptr <= (lock_id+1) mod N.
// - Invalid cycles or stalls (out_ready=0) never change ptr, the grant or the state.
// - A locked requester may drop req_valid between beats; the lock is held.
// Boundary rules
// - Wrap-around: ptr=N-1 with grant to N-1 gives next ptr 0.
// - When only the pointed requester is active, it keeps winning on later bursts.
// - Simultaneous requests from all N in IDLE: the ptr requester wins.
// - A new request arriving in the same cycle a burst ends is arbitrated next cycle with the updated ptr.
// - Reset mid-burst aborts without any completion; the downstream side must tolerate the truncated burst.
// CONFIGURATION
// - Macro: BURST_PORT_ARB_WATCHDOG_EN.
// - Defined:
//   - hold_cnt clears on entry to LOCK and increments every LOCK cycle.
//   - If hold_cnt reaches MAX_HOLD-1 without an accepted last beat, the arbiter forces IDLE next cycle.
//   - On that abort: ptr <= (lock_id+1) mod N and wdog_err pulses high for exactly 1 cycle.
//   - An accepted last beat in the abort cycle counts as normal completion, with no error.
// - Undefined: no counter is built, wdog_err is tied to 0 and a burst may hold the port forever.
// - The port list is identical in both builds.
// TESTING
// - Reset, then N=4, PRI_RST=0, req_valid=4'b1111, all last=1, out_ready=1:
//   - grants go 0,1,2,3,0; out_id tracks each grant; busy stays 0.
// - Req 1 sends a 3-beat burst (last on beat 3) while req 2 is valid throughout:
//   - out_id=1 for 3 transfers, busy=1 after beat 1; req 2 is granted the cycle after beat 3.
// - Burst in progress with out_ready=0 for 5 cycles:
//   - out_data holds, no req_ready is asserted, ptr and lock_id are unchanged, and the burst resumes.
// - ptr=3, only req 3 valid, single beat accepted:
//   - ptr wraps to 0; req 0 and req 3 then both valid gives a grant to 0.
// - Macro defined, MAX_HOLD=4, req 0 holds valid with last=0:
//   - wdog_err pulses once after 4 LOCK cycles, state returns to IDLE, ptr=1.
// - Assert rst_n low mid-burst:
//   - busy, req_ready and out_valid go to 0 immediately; after release, ptr=PRI_RST.

Source files
------------

// File: rtl/burst_port_arbiter.sv
// Round-robin arbiter that hands one valid/ready port to N requesters and holds the grant for a whole burst.
// Optional burst watchdog: define BURST_PORT_ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no burst open; arbitrate among valid requesters from ptr
// LOCK  | burst open; only lock_id is routed until its last beat
module burst_port_arbiter #(
    parameter int N        = 2,
    parameter int DW       = 32,
    parameter int PRI_RST  = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req_valid,
    input  logic [N-1:0]                 req_last,
    input  logic [N*DW-1:0]              req_data,
    output logic [N-1:0]                 req_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(N)-1:0]         out_id,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         wdog_err
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    if (N < 2 || PRI_RST < 0 || PRI_RST >= N || MAX_HOLD < 2) begin : g_bad_param
        $error("burst_port_arbiter: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   lock_id_q, lock_id_d;
    logic            wdog_err_q, wdog_err_d;

    logic [IW-1:0]   win;
    logic            any_valid;
    logic [IW-1:0]   sel;
    logic            routed;
    logic            xfer;
    logic            out_valid_c;
    logic            out_last_c;
    logic [DW-1:0]   out_data_c;
    logic [IW-1:0]   out_id_c;
    logic [N-1:0]    req_ready_c;

`ifdef BURST_PORT_ARB_WATCHDOG_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
`endif

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        return (x == IW'(N-1)) ? '0 : x + 1'b1;
    endfunction

    // Rotating search: indices at or above ptr first, then wrap to those below it.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_valid && i >= int'(ptr_q) && req_valid[i]) begin
                win       = IW'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_valid && i < int'(ptr_q) && req_valid[i]) begin
                win       = IW'(i);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel         = (state_q == LOCK) ? lock_id_q : win;
        routed      = (state_q == LOCK) || any_valid;
        out_valid_c = (state_q == LOCK) ? req_valid[sel] : any_valid;
        out_last_c  = out_valid_c & req_last[sel];
        out_data_c  = routed ? req_data[sel*DW +: DW] : '0;
        out_id_c    = routed ? sel : '0;
        req_ready_c = '0;
        if (routed) begin
            req_ready_c[sel] = out_ready;
        end
        xfer = out_valid_c & out_ready;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_id_d  = lock_id_q;
        wdog_err_d = 1'b0;
`ifdef BURST_PORT_ARB_WATCHDOG_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (out_last_c) begin
                        ptr_d = next_idx(win);
                    end else begin
                        state_d   = LOCK;
                        lock_id_d = win;
`ifdef BURST_PORT_ARB_WATCHDOG_EN
                        hold_cnt_d = '0;
`endif
                    end
                end
            end
            LOCK: begin
`ifdef BURST_PORT_ARB_WATCHDOG_EN
                hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                if (xfer && out_last_c) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(lock_id_q);
                end
`ifdef BURST_PORT_ARB_WATCHDOG_EN
                // A last beat accepted in the limit cycle is a clean completion, not an abort.
                else if (hold_cnt_q == HW'(MAX_HOLD-1)) begin
                    state_d    = IDLE;
                    ptr_d      = next_idx(lock_id_q);
                    wdog_err_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(PRI_RST);
            lock_id_q  <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_id_q  <= lock_id_d;
            wdog_err_q <= wdog_err_d;
        end
    end

`ifdef BURST_PORT_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    // Combinational outputs are forced low for the whole time reset is asserted.
    assign out_valid = rst_n & out_valid_c;
    assign out_last  = rst_n & out_last_c;
    assign out_data  = rst_n ? out_data_c : '0;
    assign out_id    = rst_n ? out_id_c : '0;
    assign req_ready = rst_n ? req_ready_c : '0;
    assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_burst_port_arbiter.sv
// Directed bench for burst_port_arbiter (N=4, DW=8, PRI_RST=0, MAX_HOLD=4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_burst_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_ready;
    logic            busy;
    logic            wdog_err;

    int tests;
    int fails;

    burst_port_arbiter #(.N(N), .DW(DW), .PRI_RST(0), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid actual=%b required=0", out_valid); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_req_ready actual=%b required=0000", req_ready); end
        tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL rst_out_id actual=%0d required=0", out_id); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data actual=%h required=00", out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy actual=%b required=0", busy); end
        tests++; if (wdog_err !== 1'b0) begin fails++; $display("FAIL rst_wdog_err actual=%b required=0", wdog_err); end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        logic [7:0] ed;
        logic [3:0] er;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e  = 2'(k % 4);
            ed = 8'hA0 + 8'(k % 4);
            er = 4'b0001 << e;
            #1;
            tests++; if (out_id !== e) begin fails++; $display("FAIL rr_out_id[%0d] actual=%0d required=%0d", k, out_id, e); end
            tests++; if (req_ready !== er) begin fails++; $display("FAIL rr_req_ready[%0d] actual=%b required=%b", k, req_ready, er); end
            tests++; if (out_data !== ed) begin fails++; $display("FAIL rr_out_data[%0d] actual=%h required=%h", k, out_data, ed); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_busy[%0d] actual=%b required=0", k, busy); end
            @(negedge clk);
        end
    endtask

    // ptr=1 on entry: req 1 bursts three beats while req 2 waits.
    task automatic test_burst();
        req_valid = 4'b0110;
        req_last  = 4'b0100;
        out_ready = 1'b1;
        #1;
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL burst_b1_id actual=%0d required=1", out_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL burst_b1_busy actual=%b required=0", busy); end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL burst_b2_busy actual=%b required=1", busy); end
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL burst_b2_id actual=%0d required=1", out_id); end
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL burst_b2_ready actual=%b required=0010", req_ready); end
        @(negedge clk);
        req_last = 4'b0110;
        #1;
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL burst_b3_id actual=%0d required=1", out_id); end
        tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL burst_b3_last actual=%b required=1", out_last); end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL burst_after_busy actual=%b required=0", busy); end
        tests++; if (out_id !== 2'd2) begin fails++; $display("FAIL burst_after_id actual=%0d required=2", out_id); end
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL burst_after_ready actual=%b required=0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        req_last  = 4'b0000;
    endtask

    // ptr=3 on entry: req 0 opens a burst, then the port stalls for 5 cycles.
    task automatic test_stall();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        #1;
        tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL stall_open_id actual=%0d required=0", out_id); end
        @(negedge clk);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] actual=%b required=1", k, out_valid); end
            tests++; if (out_data !== 8'hA0) begin fails++; $display("FAIL stall_data[%0d] actual=%h required=a0", k, out_data); end
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d] actual=%b required=0000", k, req_ready); end
            tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL stall_id[%0d] actual=%0d required=0", k, out_id); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy[%0d] actual=%b required=1", k, busy); end
            @(negedge clk);
        end
        req_valid = 4'b1110;
        out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_valid actual=%b required=0", out_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL gap_busy actual=%b required=1", busy); end
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL gap_ready actual=%b required=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1111;
        req_last  = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL resume_ready actual=%b required=0001", req_ready); end
        tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL resume_last actual=%b required=1", out_last); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL stall_ptr_id actual=%0d required=1", out_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_end_busy actual=%b required=0", busy); end
        @(negedge clk);
        #1;
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL idle_stall_id actual=%0d required=1", out_id); end
    endtask

    // ptr=1 on entry: walk it to 3, then wrap.
    task automatic test_wrap();
        out_ready = 1'b1;
        req_last  = 4'b1111;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        tests++; if (out_id !== 2'd3) begin fails++; $display("FAIL wrap_id3 actual=%0d required=3", out_id); end
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL wrap_id0 actual=%0d required=0", out_id); end
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready actual=%b required=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    // ptr=1 on entry: req 0 holds the port without ever sending a last beat.
    task automatic test_watchdog();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
`ifdef BURST_PORT_ARB_WATCHDOG_EN
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wd_busy[%0d] actual=%b required=1", k, busy); end
            tests++; if (wdog_err !== 1'b0) begin fails++; $display("FAIL wd_early_err[%0d] actual=%b required=0", k, wdog_err); end
            @(negedge clk);
        end
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #1;
        tests++; if (wdog_err !== 1'b1) begin fails++; $display("FAIL wd_pulse actual=%b required=1", wdog_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_abort_busy actual=%b required=0", busy); end
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL wd_ptr_id actual=%0d required=1", out_id); end
        @(negedge clk);
        #1;
        tests++; if (wdog_err !== 1'b0) begin fails++; $display("FAIL wd_pulse_width actual=%b required=0", wdog_err); end
`else
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_busy[%0d] actual=%b required=1", k, busy); end
            tests++; if (wdog_err !== 1'b0) begin fails++; $display("FAIL hold_err[%0d] actual=%b required=0", k, wdog_err); end
            @(negedge clk);
        end
        req_last = 4'b0001;
        @(negedge clk);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_end_busy actual=%b required=0", busy); end
        tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL hold_ptr_id actual=%0d required=1", out_id); end
`endif
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    // ptr=1 on entry: req 2 opens a burst, reset lands in the middle.
    task automatic test_reset_mid_burst();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre actual=%b required=1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy actual=%b required=0", busy); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready actual=%b required=0000", req_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid actual=%b required=0", out_valid); end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b0;
        #1;
        tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL mid_ptr_id actual=%0d required=0", out_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_after_busy actual=%b required=0", busy); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_round_robin();
        test_burst();
        test_stall();
        test_wrap();
        test_watchdog();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
